// File: rtl/hex_scan_if.sv
// Scan-controller bus: enable, value load handshake and the registered display outputs.
interface hex_scan_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic [4*DIGITS-1:0]   value;
  logic                  load;
  logic [3:0]            nibble;
  logic [DIGITS-1:0]     an;
  logic                  pending;
  logic                  applied;

  modport master (
    output en, value, load,
    input  nibble, an, pending, applied
  );

  modport slave (
    input  en, value, load,
    output nibble, an, pending, applied
  );
endinterface

// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with double-buffered value updates.
// Optional leading-zero blanking is enabled by defining HEX_SCAN_LZB_EN.
module hex_scan_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int GUARD    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  hex_scan_if.slave  bus
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PW-1:0]          r_pcnt;
  logic [IW-1:0]          r_idx;
  logic [4*DIGITS-1:0]    r_disp;
  logic [4*DIGITS-1:0]    r_shadow;
  logic                   r_pending;
  logic                   r_applied;
  logic [3:0]             r_nibble;
  logic [DIGITS-1:0]      r_an;

  logic                   w_tick;
  logic                   w_last;
  logic                   w_frame_end;
  logic                   w_apply;
  logic [PW-1:0]          w_pcnt_nxt;
  logic [IW-1:0]          w_idx_nxt;
  logic [3:0]             w_nib;
  logic                   w_blank;
  logic                   w_dark;
  logic [DIGITS-1:0]      w_an_nxt;

`ifdef HEX_SCAN_LZB_EN
  logic [DIGITS-1:0]      w_zero_from;

  // w_zero_from[i]: display digits i..DIGITS-1 are all zero
  always_comb begin
    w_zero_from = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_zero_from[i] = ((r_disp >> (4 * i)) == '0);
    end
    w_blank = (r_idx != '0) && w_zero_from[r_idx];
  end
`else
  assign w_blank = 1'b0;
`endif

  always_comb begin
    w_tick      = bus.en && (r_pcnt == PW'(PRESCALE - 1));
    w_last      = (r_idx == IW'(DIGITS - 1));
    // While disabled every cycle counts as a frame boundary so loads apply at once
    w_frame_end = !bus.en || (w_tick && w_last);
    w_apply     = w_frame_end && r_pending;

    w_pcnt_nxt = r_pcnt + PW'(1);
    w_idx_nxt  = r_idx;
    if (!bus.en) begin
      w_pcnt_nxt = '0;
      w_idx_nxt  = '0;
    end else if (w_tick) begin
      w_pcnt_nxt = '0;
      w_idx_nxt  = w_last ? '0 : r_idx + IW'(1);
    end

    w_nib = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == IW'(i)) w_nib = r_disp[4*i +: 4];
    end

    w_dark   = !bus.en || (r_pcnt < PW'(GUARD)) || w_blank;
    w_an_nxt = w_dark ? '1 : ~(DIGITS'(1) << r_idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt    <= '0;
      r_idx     <= '0;
      r_disp    <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_applied <= 1'b0;
      r_nibble  <= 4'h0;
      r_an      <= '1;
    end else begin
      r_pcnt    <= w_pcnt_nxt;
      r_idx     <= w_idx_nxt;
      r_nibble  <= w_nib;
      r_an      <= w_an_nxt;
      r_applied <= w_apply;
      if (w_apply) r_disp <= r_shadow;
      // A load on the apply edge keeps pending set for the newly captured value
      if (bus.load) begin
        r_shadow  <= bus.value;
        r_pending <= 1'b1;
      end else if (w_apply) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign bus.nibble  = r_nibble;
  assign bus.an      = r_an;
  assign bus.pending = r_pending;
  assign bus.applied = r_applied;
endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Directed bench for hex_scan_ctrl (DIGITS=4, PRESCALE=8, GUARD=2).
module tb_hex_scan_ctrl;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   n = 0;
  int   cnt;

  hex_scan_if #(.DIGITS(4)) bus ();

  hex_scan_ctrl #(.DIGITS(4), .PRESCALE(8), .GUARD(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic to_edge(input int t);
    while (n < t) cyc(1);
  endtask

  // expected lit-slot enable for slot s given the displayed value d
  function automatic logic [3:0] exp_an(input int s, input logic [15:0] d);
    logic [3:0] one;
    one = 4'b0001;
`ifdef HEX_SCAN_LZB_EN
    if (s > 0 && (d >> (4 * s)) == 16'h0) return 4'hF;
`endif
    return ~(one << s);
  endfunction

  initial begin
    rst_n = 1'b0;
    bus.en = 1'b0;
    bus.value = 16'h0;
    bus.load = 1'b0;
    #12;
    chk("rst_an", bus.an, 4'hF);
    chk("rst_nib", bus.nibble, 4'h0);
    chk("rst_pend", bus.pending, 1'b0);
    chk("rst_appl", bus.applied, 1'b0);

    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.en = 1'b1;
    n = 0;

    // frame 1: empty display, slot timing
    to_edge(1);  chk("f1_guard0", bus.an, 4'hF);
    to_edge(3);  chk("f1_s0_an", bus.an, 4'hE); chk("f1_s0_nib", bus.nibble, 4'h0);
    to_edge(8);  chk("f1_s0_end", bus.an, 4'hE);
    to_edge(9);  chk("f1_guard1", bus.an, 4'hF);
    to_edge(11); chk("f1_s1_an", bus.an, exp_an(1, 16'h0));
    to_edge(19); chk("f1_s2_an", bus.an, exp_an(2, 16'h0));
    to_edge(27); chk("f1_s3_an", bus.an, exp_an(3, 16'h0));

    // frame 2: load mid-frame, apply at frame end
    to_edge(34);
    bus.value = 16'hA5C3; bus.load = 1'b1;
    cyc(1);
    bus.load = 1'b0;
    chk("ld_pend", bus.pending, 1'b1);
    chk("ld_appl", bus.applied, 1'b0);
    to_edge(63); chk("pre_fe_appl", bus.applied, 1'b0); chk("pre_fe_pend", bus.pending, 1'b1);
    to_edge(64); chk("fe_appl", bus.applied, 1'b1); chk("fe_pend", bus.pending, 1'b0);
    to_edge(65); chk("post_appl", bus.applied, 1'b0); chk("f3_g_nib", bus.nibble, 4'h3);
    chk("f3_g_an", bus.an, 4'hF);
    to_edge(67); chk("f3_d0", bus.nibble, 4'h3); chk("f3_a0", bus.an, 4'hE);
    to_edge(75); chk("f3_d1", bus.nibble, 4'hC); chk("f3_a1", bus.an, exp_an(1, 16'hA5C3));
    to_edge(83); chk("f3_d2", bus.nibble, 4'h5); chk("f3_a2", bus.an, exp_an(2, 16'hA5C3));
    to_edge(91); chk("f3_d3", bus.nibble, 4'hA); chk("f3_a3", bus.an, exp_an(3, 16'hA5C3));

    // frame 4: two loads, latest wins, single applied pulse
    to_edge(100);
    bus.value = 16'h1111; bus.load = 1'b1;
    cyc(1); bus.load = 1'b0;
    to_edge(105);
    bus.value = 16'h2222; bus.load = 1'b1;
    cyc(1); bus.load = 1'b0;
    cnt = 0;
    while (n < 130) begin
      cyc(1);
      if (bus.applied === 1'b1) cnt++;
    end
    chk("dbl_pulses", cnt, 1);
    to_edge(131); chk("dbl_nib0", bus.nibble, 4'h2); chk("dbl_an0", bus.an, 4'hE);

    // load 1234, then 00F0 on the exact frame-end edge
    to_edge(140);
    bus.value = 16'h1234; bus.load = 1'b1;
    cyc(1); bus.load = 1'b0;
    to_edge(147); chk("f5_nib2", bus.nibble, 4'h2); chk("f5_pend", bus.pending, 1'b1);
    to_edge(159);
    bus.value = 16'h00F0; bus.load = 1'b1;
    cyc(1); bus.load = 1'b0;
    chk("sim_appl", bus.applied, 1'b1);
    chk("sim_pend", bus.pending, 1'b1);
    to_edge(163); chk("f6_d0", bus.nibble, 4'h4); chk("f6_a0", bus.an, 4'hE);
    to_edge(171); chk("f6_d1", bus.nibble, 4'h3);
    to_edge(190); chk("f6_pend", bus.pending, 1'b1); chk("f6_appl", bus.applied, 1'b0);
    to_edge(192); chk("f6_fe_appl", bus.applied, 1'b1); chk("f6_fe_pend", bus.pending, 1'b0);
    to_edge(195); chk("f7_d0", bus.nibble, 4'h0); chk("f7_a0", bus.an, 4'hE);
    to_edge(203); chk("f7_d1", bus.nibble, 4'hF); chk("f7_a1", bus.an, exp_an(1, 16'h00F0));

    // disabled: load applies immediately, display dark
    bus.en = 1'b0; bus.value = 16'hBEEF; bus.load = 1'b1;
    cyc(1); bus.load = 1'b0;
    chk("dis_an", bus.an, 4'hF); chk("dis_pend", bus.pending, 1'b1); chk("dis_appl0", bus.applied, 1'b0);
    cyc(1);
    chk("dis_appl", bus.applied, 1'b1); chk("dis_pend0", bus.pending, 1'b0); chk("dis_an2", bus.an, 4'hF);
    cyc(1);
    chk("dis_appl_end", bus.applied, 1'b0); chk("dis_nib", bus.nibble, 4'hF); chk("dis_an3", bus.an, 4'hF);
    bus.en = 1'b1;
    cyc(2); chk("en_guard", bus.an, 4'hF);
    cyc(1); chk("en_s0_an", bus.an, 4'hE); chk("en_s0_nib", bus.nibble, 4'hF);
    cyc(2); chk("en_s0_mid", bus.an, 4'hE);
    bus.en = 1'b0;
    cyc(1); chk("mid_dis_an", bus.an, 4'hF); chk("mid_dis_nib", bus.nibble, 4'hF);
    bus.en = 1'b1;
    cyc(3); chk("reen_an", bus.an, 4'hE); chk("reen_nib", bus.nibble, 4'hF);

    // reset mid-slot with a pending shadow
    bus.value = 16'h1234; bus.load = 1'b1;
    cyc(1); bus.load = 1'b0;
    chk("prerst_pend", bus.pending, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_an", bus.an, 4'hF); chk("mrst_nib", bus.nibble, 4'h0);
    chk("mrst_pend", bus.pending, 1'b0); chk("mrst_appl", bus.applied, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(3); chk("prst_an", bus.an, 4'hE); chk("prst_nib", bus.nibble, 4'h0);
    cnt = 0;
    repeat (40) begin
      cyc(1);
      if (bus.applied === 1'b1) cnt++;
    end
    chk("prst_pulses", cnt, 0);
    chk("prst_pend", bus.pending, 1'b0);

`ifdef HEX_SCAN_LZB_EN
    bus.en = 1'b0; bus.value = 16'h0070; bus.load = 1'b1;
    cyc(1); bus.load = 1'b0;
    cyc(1); bus.en = 1'b1;
    cyc(3);  chk("lzb_a0", bus.an, 4'hE); chk("lzb_d0", bus.nibble, 4'h0);
    cyc(8);  chk("lzb_a1", bus.an, 4'hD); chk("lzb_d1", bus.nibble, 4'h7);
    cyc(8);  chk("lzb_a2", bus.an, 4'hF);
    cyc(8);  chk("lzb_a3", bus.an, 4'hF);
    bus.en = 1'b0; bus.value = 16'h0000; bus.load = 1'b1;
    cyc(1); bus.load = 1'b0;
    cyc(1); bus.en = 1'b1;
    cyc(3);  chk("lzb0_a0", bus.an, 4'hE); chk("lzb0_d0", bus.nibble, 4'h0);
    cyc(8);  chk("lzb0_a1", bus.an, 4'hF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
